// File: rtl/piso_shift_controller.sv
// Parallel-in/serial-out sequencer: accepts an N-bit word over valid/ready and shifts it out one bit per shift_en.
// Optional even-parity trailer bit when PISO_SHIFT_CONTROLLER_PARITY_EN is defined.
module piso_shift_controller #(
  parameter int N         = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  input  logic         shift_en,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         ser_last,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  // Handshake: a word transfers on any rising edge where in_valid and in_ready are both 1;
  // the producer must hold in_valid/in_data stable until that edge, and in_ready never
  // depends combinationally on in_valid.

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  shreg;
  logic [CW-1:0] cnt;
  logic [N-1:0]  shreg_rot;
  logic [CW-1:0] cnt_inc;
  logic          next_bit;
`ifdef PISO_SHIFT_CONTROLLER_PARITY_EN
  logic          par;
`endif

  // Rotate rather than shift so the register content is never partially discarded.
  always_comb begin
    shreg_rot = shreg;
    next_bit  = 1'b0;
    cnt_inc   = cnt + CW'(1);
    if (LSB_FIRST) begin
      shreg_rot = {shreg[0], shreg[N-1:1]};
      next_bit  = shreg[1];
    end else begin
      shreg_rot = {shreg[N-2:0], shreg[N-1]};
      next_bit  = shreg[N-2];
    end
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      busy      <= 1'b0;
`ifdef PISO_SHIFT_CONTROLLER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state     <= SHIFT;
            shreg     <= in_data;
            cnt       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            ser_valid <= 1'b1;
            ser_last  <= 1'b0;
            ser_out   <= LSB_FIRST ? in_data[0] : in_data[N-1];
`ifdef PISO_SHIFT_CONTROLLER_PARITY_EN
            par       <= ^in_data;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end

        SHIFT: begin
          if (shift_en) begin
            if (cnt == LAST) begin
`ifdef PISO_SHIFT_CONTROLLER_PARITY_EN
              state     <= PARITY;
              ser_out   <= par;
              ser_last  <= 1'b1;
`else
              state     <= IDLE;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
`endif
            end else begin
              shreg    <= shreg_rot;
              cnt      <= cnt_inc;
              ser_out  <= next_bit;
`ifdef PISO_SHIFT_CONTROLLER_PARITY_EN
              ser_last <= 1'b0;
`else
              ser_last <= (cnt_inc == LAST);
`endif
            end
          end
        end

        // PARITY slot; in the plain build this also recovers any unused encoding.
        default: begin
`ifdef PISO_SHIFT_CONTROLLER_PARITY_EN
          if (shift_en) begin
            state     <= IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
`else
          state     <= IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          ser_last  <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_shift_controller.sv
// Bench for piso_shift_controller: LSB-first and MSB-first instances share stimulus,
// each checked against its own expected-bit queue.
module tb_piso_shift_controller;

  localparam int N = 4;
`ifdef PISO_SHIFT_CONTROLLER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [N-1:0] in_data  = '0;
  logic         shift_en = 1'b0;

  logic       a_in_ready, a_ser_out, a_ser_valid, a_ser_last, a_busy;
  logic [1:0] a_state;
  logic       m_in_ready, m_ser_out, m_ser_valid, m_ser_last, m_busy;
  logic [1:0] m_state;

  piso_shift_controller #(.N(N), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .shift_en(shift_en), .ser_out(a_ser_out), .ser_valid(a_ser_valid),
    .ser_last(a_ser_last), .busy(a_busy), .state_dbg(a_state)
  );

  piso_shift_controller #(.N(N), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(m_in_ready),
    .shift_en(shift_en), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .ser_last(m_ser_last), .busy(m_busy), .state_dbg(m_state)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard: entries are {last, bit}
  logic [1:0] exp_q[$];
  logic [1:0] exp_m_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] w);
    logic l;
    for (int i = 0; i < N; i++) begin
      l = (i == N - 1) && !PAR;
      exp_q.push_back({l, w[i]});
      exp_m_q.push_back({l, w[N-1-i]});
    end
    if (PAR) begin
      exp_q.push_back({1'b1, ^w});
      exp_m_q.push_back({1'b1, ^w});
    end
  endtask

  // monitor: a bit is consumed on an edge where ser_valid and shift_en are both high
  logic [1:0] e_a, e_m;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (a_ser_valid && shift_en) begin
        if (exp_q.size() == 0) check("lsb_unexpected_bit", 32'd1, 32'd0);
        else begin
          e_a = exp_q.pop_front();
          check("lsb_bit", {30'd0, a_ser_last, a_ser_out}, {30'd0, e_a});
          check("lsb_busy", {31'd0, a_busy}, 32'd1);
        end
      end else if (!a_ser_valid) begin
        check("lsb_idle_last", {31'd0, a_ser_last}, 32'd0);
      end
      if (m_ser_valid && shift_en) begin
        if (exp_m_q.size() == 0) check("msb_unexpected_bit", 32'd1, 32'd0);
        else begin
          e_m = exp_m_q.pop_front();
          check("msb_bit", {30'd0, m_ser_last, m_ser_out}, {30'd0, e_m});
        end
      end
    end
  end

  // driver tasks
  task automatic send_word(input logic [N-1:0] w);
    int g = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    do begin
      acc = a_in_ready;
      if (acc) push_exp(w);
      @(posedge clk); #1;
      g++;
    end while (!acc && g < 100);
    in_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic frame_len(input string tag);
    int n = 0;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, n, PAR ? N + 1 : N);
    check({tag, "_valid_drop"}, {31'd0, a_ser_valid}, 32'd0);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((!a_in_ready || exp_q.size() != 0) && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 300) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, a_in_ready}, 32'd0);
    check({tag, "_ser_out"}, {31'd0, a_ser_out}, 32'd0);
    check({tag, "_ser_valid"}, {31'd0, a_ser_valid}, 32'd0);
    check({tag, "_ser_last"}, {31'd0, a_ser_last}, 32'd0);
    check({tag, "_busy"}, {31'd0, a_busy}, 32'd0);
    check({tag, "_state"}, {30'd0, a_state}, 32'd0);
    check({tag, "_msb_ready"}, {31'd0, m_in_ready}, 32'd0);
  endtask

  initial begin
    int g;
    logic [N-1:0] w;

    // reset held with a word offered: nothing accepted
    rst = 1'b0; in_valid = 1'b1; in_data = 4'b1001; shift_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {31'd0, a_in_ready}, 32'd1);
    check("idle_after_reset", {31'd0, a_busy}, 32'd0);
    // in_valid still high as in_ready rises: accepted on the next edge
    push_exp(4'b1001);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("accept_on_ready_rise_busy", {31'd0, a_busy}, 32'd1);
    check("accept_on_ready_rise_ready", {31'd0, a_in_ready}, 32'd0);
    check("first_bit_latency", {31'd0, a_ser_valid}, 32'd1);
    wait_idle();

    // basic frame and MSB-first ordering
    send_word(4'b1010);
    frame_len("frame_len_1010");
    send_word(4'b1100);
    frame_len("frame_len_1100");

    // stall after bit 1 of 0110
    send_word(4'b0110);
    @(posedge clk); #1;
    shift_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold_out", {31'd0, a_ser_out}, 32'd1);
      check("stall_hold_last", {31'd0, a_ser_last}, 32'd0);
      @(posedge clk); #1;
    end
    shift_en = 1'b1;
    wait_idle();

    // producer offers a word during SHIFT: ignored
    send_word(4'b0011);
    in_valid = 1'b1; in_data = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("no_accept_in_shift", {31'd0, a_in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_idle();

    // reset mid-frame at bit 2
    send_word(4'b0101);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    exp_q.delete();
    exp_m_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_abort", {31'd0, a_in_ready}, 32'd1);
    send_word(4'b1101);
    frame_len("frame_len_after_abort");

    // parity example word (plain frame when the option is off)
    send_word(4'b0111);
    frame_len("frame_len_0111");

    // random words with random consumer stalls
    for (int k = 0; k < 8; k++) begin
      w = N'($urandom_range(0, (1 << N) - 1));
      send_word(w);
      g = 0;
      while (!a_in_ready && g < 200) begin
        shift_en = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        g++;
      end
      shift_en = 1'b1;
      if (g >= 200) check("random_frame_timeout", 32'd0, 32'd1);
    end

    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("lsb_queue_empty", exp_q.size(), 32'd0);
    check("msb_queue_empty", exp_m_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
